// File: rtl/result_serializer_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : result_serializer_fifo_if
//  Description : Handshake/bus bundle for result_serializer_fifo.
//                master : result generator + downstream reader side
//                slave  : result_serializer_fifo side
//                Signals: load_en, final_result, rd_en (to serializer);
//                         read_data, fifo_empty, fifo_full, fifo_count,
//                         busy, frame_done (from serializer);
//                         overrun (from serializer, only with RSER_OVERRUN_EN).
//  Config      : RSER_OVERRUN_EN adds the sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface result_serializer_fifo_if #(
    parameter int RESULT_W   = 3072,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int AW         = $clog2(FIFO_DEPTH)
);
    logic                load_en;
    logic [RESULT_W-1:0] final_result;
    logic                rd_en;
    logic [WORD_W-1:0]   read_data;
    logic                fifo_empty;
    logic                fifo_full;
    logic [AW:0]         fifo_count;
    logic                busy;
    logic                frame_done;
`ifdef RSER_OVERRUN_EN
    logic                overrun;

    modport master (
        output load_en, final_result, rd_en,
        input  read_data, fifo_empty, fifo_full, fifo_count, busy, frame_done, overrun
    );
    modport slave (
        input  load_en, final_result, rd_en,
        output read_data, fifo_empty, fifo_full, fifo_count, busy, frame_done, overrun
    );
`else
    modport master (
        output load_en, final_result, rd_en,
        input  read_data, fifo_empty, fifo_full, fifo_count, busy, frame_done
    );
    modport slave (
        input  load_en, final_result, rd_en,
        output read_data, fifo_empty, fifo_full, fifo_count, busy, frame_done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/result_serializer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : result_serializer_fifo
//  Description : Captures one RESULT_W-bit result, slices it into WORD_W-bit
//                words (LSB word first) and pushes them into an internal
//                FIFO_DEPTH-entry FIFO, stalling while the FIFO is full.
//  Ports       : clk_in - clock
//                rst    - asynchronous active-high reset
//                bus    - result_serializer_fifo_if.slave
//                         (load_en/final_result capture, rd_en/read_data pop,
//                          fifo_empty/fifo_full/fifo_count status,
//                          busy/frame_done frame status, optional overrun)
//  Config      : RSER_OVERRUN_EN - adds sticky overrun flag, set when load_en
//                arrives while a frame is in progress; cleared by rst only.
//  Note        : The interface instance must carry the same RESULT_W, WORD_W
//                and FIFO_DEPTH as this module.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_serializer_fifo #(
    parameter int RESULT_W   = 3072,
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 256,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                     clk_in,
    input  logic                     rst,
    result_serializer_fifo_if.slave  bus
);

    localparam int NWORDS = RESULT_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(NWORDS - 1);
    localparam logic [AW:0]      DEPTH_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [RESULT_W-1:0] cache_q;
    logic [CNT_W-1:0]    word_cnt_q;
    logic                busy_q;
    logic                frame_done_q;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic                empty_q;
    logic                full_q;
    logic [WORD_W-1:0]   read_data_q;

    logic                w_push;
    logic                w_pop;
    logic                w_last;

    // Full/empty are the registered flags, so a pop at full cannot free a
    // slot for a push on the same edge.
    assign w_push = (state_q == ST_PUSH) && !full_q;
    assign w_pop  = bus.rd_en && !empty_q;
    assign w_last = (word_cnt_q == LAST_WORD);

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM: outputs busy/frame_done are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cache_q      <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.load_en) begin
                        cache_q    <= bus.final_result;
                        word_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    // Stalled while full: cache and word count hold.
                    if (!full_q) begin
                        cache_q    <= cache_q >> WORD_W;
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (w_last) begin
                            word_cnt_q   <= '0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: validity is tracked by the pointers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= cache_q[WORD_W-1:0];
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                read_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH_FULL);
        end
    end

`ifdef RSER_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if (bus.load_en && busy_q) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`endif

    assign bus.read_data  = read_data_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_count = count_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
